// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32 immediate generator feeding a small valid/ready FIFO.
//
// The immediate is decoded and extended combinationally when an entry is pushed.
// The stored value and its illegal flag come out in FIFO order, one cycle later
// at the earliest.
//
// Parameters
//   XLEN  - width of the extended immediate (32 or 64)
//   DEPTH - number of buffer entries (2..8, any value)
//
// Ports
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   flush       - synchronous discard of every buffered entry (beats push/pop)
//   in_valid    - instr/immsrc valid
//   in_ready    - buffer can take an entry (registered, independent of out_ready)
//   instr       - RV32 instruction word
//   immsrc      - format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 11x illegal
//   out_valid   - head entry present
//   out_ready   - consumer takes the head entry
//   imm_ext     - extended immediate of the head entry (zero when empty)
//   imm_illegal - head entry was pushed with an illegal format select
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_illegal
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Immediate decode. Everything is built at 64 bits and truncated to XLEN, so
  // the U format sign-extends only when XLEN is 64.
  // ---------------------------------------------------------------------------
  logic [63:0]     imm_full;
  logic [XLEN-1:0] imm_new;
  logic            illegal_new;

  always_comb begin
    imm_full    = '0;
    illegal_new = 1'b0;
    case (immsrc)
      3'b000: imm_full = {{52{instr[31]}}, instr[31:20]};
      3'b001: imm_full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: imm_full = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      3'b011: imm_full = {{32{instr[31]}}, instr[31:12], 12'b0};
      3'b100: imm_full = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      3'b101: imm_full = {59'b0, instr[19:15]};
      default: begin
        imm_full    = '0;
        illegal_new = 1'b1;
      end
    endcase
  end

  assign imm_new = imm_full[XLEN-1:0];

  // Opcode field and the upper half at XLEN=32 are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{instr[6:0], imm_full};

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            ready_q, ready_d;
  logic            push, pop;

  logic [XLEN-1:0] data_q    [DEPTH];
  logic            illegal_q [DEPTH];

  assign out_valid = (count_q != '0);
  assign in_ready  = ready_q;

  // flush squashes both handshakes so neither pointer nor storage moves.
  assign push = in_valid & ready_q & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
    // Registered so in_ready never depends combinationally on out_ready.
    ready_d = (count_d < DepthCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q]    <= imm_new;
      illegal_q[wr_ptr_q] <= illegal_new;
    end
  end

  // Outputs read zero when empty, which also covers reset.
  always_comb begin
    imm_ext     = '0;
    imm_illegal = 1'b0;
    if (out_valid) begin
      imm_ext     = data_q[rd_ptr_q];
      imm_illegal = illegal_q[rd_ptr_q];
    end
  end

endmodule
